// File: rtl/pipe_pkg.sv
// Shared types for the pipeline sequencer: FSM state encoding and the
// per-stage enable/flush bundle handed from the hazard logic to the top.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        STEP = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_en;
        logic memwb_en;
        logic memwb_flush;
    } stage_ctl_t;

    localparam stage_ctl_t CTL_FREEZE = '0;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs, debug controls and stage-control outputs of the sequencer.
// The core/debugger side is the master, pipe_ctrl is the slave.
interface pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             idex_memread;
    logic [4:0]       idex_rt;
    logic [4:0]       ifid_rs;
    logic [4:0]       ifid_rt;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             bp_hit;
    logic             dbg_halt_req;
    logic             dbg_step;
    logic             dbg_resume;

    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_en;
    logic             memwb_en;
    logic             memwb_flush;
    logic             halted;
    logic             step_done;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output idex_memread, idex_rt, ifid_rs, ifid_rt, branch_taken,
               mem_req, mem_ready, bp_hit, dbg_halt_req, dbg_step, dbg_resume,
        input  pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_en,
               memwb_flush, halted, step_done, mem_err, stall_cnt
    );

    modport slave (
        input  idex_memread, idex_rt, ifid_rs, ifid_rt, branch_taken,
               mem_req, mem_ready, bp_hit, dbg_halt_req, dbg_step, dbg_resume,
        output pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_en,
               memwb_flush, halted, step_done, mem_err, stall_cnt
    );

endinterface

// File: rtl/pipe_ctrl_hazard_unit.sv
// Combinational advance logic: memory wait > taken branch > load-use > run.
module hazard_unit
    import pipe_pkg::*;
(
    input  logic       memread_i,
    input  logic [4:0] idex_rt_i,
    input  logic [4:0] ifid_rs_i,
    input  logic [4:0] ifid_rt_i,
    input  logic       branch_taken_i,
    input  logic       mem_req_i,
    input  logic       mem_ready_i,
    output stage_ctl_t ctl_o,
    output logic       memwait_o
);

    logic loaduse;

    assign memwait_o = mem_req_i & ~mem_ready_i;
    assign loaduse   = memread_i & (idex_rt_i != 5'd0) &
                       ((idex_rt_i == ifid_rs_i) | (idex_rt_i == ifid_rt_i));

    always_comb begin
        ctl_o = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0,
                  exmem_en: 1'b1, memwb_en: 1'b1, memwb_flush: 1'b0};
        if (memwait_o) begin
            // Freeze upstream, drain a bubble into WB while the access is pending.
            ctl_o.pc_en       = 1'b0;
            ctl_o.ifid_en     = 1'b0;
            ctl_o.exmem_en    = 1'b0;
            ctl_o.memwb_flush = 1'b1;
        end else if (branch_taken_i) begin
            ctl_o.ifid_flush = 1'b1;
            ctl_o.idex_flush = 1'b1;
        end else if (loaduse) begin
            ctl_o.pc_en      = 1'b0;
            ctl_o.ifid_en    = 1'b0;
            ctl_o.idex_flush = 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: run/halt/step FSM, memory-timeout detection and stall
// counting wrapped around the combinational hazard unit.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic      clk,
    input  logic      rst,
    pipe_ctrl_if.slave bus
);

    localparam int             WC_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    state_t           state_q;
    logic             skip_bp_q;
    logic             step_done_q;
    logic             mem_err_q;
    logic [WC_W-1:0]  wait_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;

    stage_ctl_t adv;
    stage_ctl_t ctl;
    logic       memwait;
    logic       halt_cond;
    logic       halt_now;
    logic       timeout;

    hazard_unit u_hazard (
        .memread_i      (bus.idex_memread),
        .idex_rt_i      (bus.idex_rt),
        .ifid_rs_i      (bus.ifid_rs),
        .ifid_rt_i      (bus.ifid_rt),
        .branch_taken_i (bus.branch_taken),
        .mem_req_i      (bus.mem_req),
        .mem_ready_i    (bus.mem_ready),
        .ctl_o          (adv),
        .memwait_o      (memwait)
    );

    assign halt_cond = bus.dbg_halt_req | (bus.bp_hit & ~skip_bp_q);
    // A halt request waits for an in-flight access unless the access has timed out.
    assign timeout   = (state_q != HALT) & memwait & (wait_cnt_q == WC_LAST);

    always_comb begin
        ctl      = CTL_FREEZE;
        halt_now = 1'b0;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (halt_cond && !memwait) halt_now = 1'b1;
                    else                       ctl      = adv;
                end
                STEP:    ctl = adv;
                default: ctl = CTL_FREEZE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            skip_bp_q   <= 1'b0;
            step_done_q <= 1'b0;
            mem_err_q   <= 1'b0;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            step_done_q <= 1'b0;
            skip_bp_q   <= 1'b0;

            if (!memwait)                  wait_cnt_q <= '0;
            else if (wait_cnt_q != WC_LAST) wait_cnt_q <= wait_cnt_q + 1'b1;

            if (state_q != HALT && !ctl.pc_en && stall_cnt_q != {CNT_W{1'b1}})
                stall_cnt_q <= stall_cnt_q + 1'b1;

            if (bus.dbg_resume) mem_err_q <= 1'b0;
            if (timeout)        mem_err_q <= 1'b1;

            case (state_q)
                RUN: begin
                    if (timeout || halt_now) state_q <= HALT;
                end
                STEP: begin
                    if (timeout) begin
                        state_q <= HALT;
                    end else if (ctl.pc_en) begin
                        state_q     <= HALT;
                        step_done_q <= 1'b1;
                    end
                end
                HALT: begin
                    if (bus.dbg_resume) begin
                        state_q   <= RUN;
                        skip_bp_q <= 1'b1;
                    end else if (bus.dbg_step) begin
                        state_q <= STEP;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign bus.pc_en       = ctl.pc_en;
    assign bus.ifid_en     = ctl.ifid_en;
    assign bus.ifid_flush  = ctl.ifid_flush;
    assign bus.idex_flush  = ctl.idex_flush;
    assign bus.exmem_en    = ctl.exmem_en;
    assign bus.memwb_en    = ctl.memwb_en;
    assign bus.memwb_flush = ctl.memwb_flush;
    assign bus.halted      = (state_q == HALT);
    assign bus.step_done   = step_done_q;
    assign bus.mem_err     = mem_err_q;
    assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: table of advance-logic vectors plus
// hand-written multi-cycle sequences for halt, step, timeout and reset.
module tb_pipe_ctrl;

    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       memread;
        logic [4:0] ex_rt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       br;
        logic       req;
        logic       rdy;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs [12];

    // {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_en, memwb_flush}
    function automatic logic [6:0] ctl_now();
        return {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_flush,
                bus.exmem_en, bus.memwb_en, bus.memwb_flush};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.idex_memread = 1'b0; bus.idex_rt = 5'd0; bus.ifid_rs = 5'd0; bus.ifid_rt = 5'd0;
        bus.branch_taken = 1'b0; bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
        bus.bp_hit = 1'b0; bus.dbg_halt_req = 1'b0; bus.dbg_step = 1'b0; bus.dbg_resume = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 7'b1100110};
        vecs[1]  = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 7'b0001110};
        vecs[2]  = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 7'b1100110};
        vecs[3]  = '{1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 7'b0001110};
        vecs[4]  = '{1'b1, 5'd5, 5'd6, 5'd7, 1'b0, 1'b0, 1'b0, 7'b1100110};
        vecs[5]  = '{1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 7'b1100110};
        vecs[6]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 7'b1111110};
        vecs[7]  = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 7'b1111110};
        vecs[8]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 7'b0000011};
        vecs[9]  = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 7'b0000011};
        vecs[10] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 7'b1100110};
        vecs[11] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 7'b1100110};

        idle_inputs();
        rst = 1'b1;
        #1;
        check("rst_ctl", 32'(ctl_now()), 32'h0);
        check("rst_halted", 32'(bus.halted), 32'h0);
        tick();
        rst = 1'b0;
        #1;
        check("rst_step_done", 32'(bus.step_done), 32'h0);
        check("rst_mem_err", 32'(bus.mem_err), 32'h0);
        check("rst_stall_cnt", 32'(bus.stall_cnt), 32'h0);

        // Advance-logic table, applied in RUN
        for (int i = 0; i < 12; i++) begin
            bus.idex_memread = vecs[i].memread;
            bus.idex_rt      = vecs[i].ex_rt;
            bus.ifid_rs      = vecs[i].rs;
            bus.ifid_rt      = vecs[i].rt;
            bus.branch_taken = vecs[i].br;
            bus.mem_req      = vecs[i].req;
            bus.mem_ready    = vecs[i].rdy;
            #1;
            check($sformatf("adv_vec%0d", i), 32'(ctl_now()), 32'(vecs[i].exp));
            tick();
        end
        idle_inputs();

        // Load-use stalls for exactly one cycle
        do_reset();
        bus.idex_memread = 1'b1; bus.idex_rt = 5'd5; bus.ifid_rs = 5'd5;
        #1;
        check("lu_pc_en", 32'(bus.pc_en), 32'h0);
        check("lu_idex_flush", 32'(bus.idex_flush), 32'h1);
        tick();
        idle_inputs();
        #1;
        check("lu_release", 32'(ctl_now()), 32'h66);
        check("lu_stall_cnt", 32'(bus.stall_cnt), 32'h1);
        bus.idex_memread = 1'b1; bus.idex_rt = 5'd0; bus.ifid_rs = 5'd0;
        #1;
        check("lu_r0_pc_en", 32'(bus.pc_en), 32'h1);
        tick();
        check("lu_r0_stall_cnt", 32'(bus.stall_cnt), 32'h1);
        idle_inputs();

        // Memory wait with a taken branch pending
        do_reset();
        bus.mem_req = 1'b1; bus.branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("mw_ctl_c%0d", i), 32'(ctl_now()), 32'h03);
            tick();
        end
        bus.mem_ready = 1'b1;
        #1;
        check("mw_branch_after", 32'(ctl_now()), 32'h7E);
        tick();
        check("mw_stall_cnt", 32'(bus.stall_cnt), 32'h3);
        idle_inputs();

        // Breakpoint halt, resume with bp still high
        do_reset();
        bus.bp_hit = 1'b1;
        #1;
        check("bp_freeze", 32'(ctl_now()), 32'h0);
        check("bp_not_halted_yet", 32'(bus.halted), 32'h0);
        tick();
        check("bp_halted", 32'(bus.halted), 32'h1);
        bus.dbg_resume = 1'b1;
        tick();
        bus.dbg_resume = 1'b0;
        #1;
        check("bp_resume_run", 32'(bus.halted), 32'h0);
        check("bp_skip_advance", 32'(bus.pc_en), 32'h1);
        tick();
        check("bp_rehit", 32'(bus.pc_en), 32'h0);
        tick();
        bus.bp_hit = 1'b0;
        check("bp_rehalt", 32'(bus.halted), 32'h1);
        check("bp_stall_cnt", 32'(bus.stall_cnt), 32'h2);

        // Single step across a load-use
        bus.dbg_step = 1'b1;
        bus.idex_memread = 1'b1; bus.idex_rt = 5'd5; bus.ifid_rs = 5'd5;
        #1;
        check("st_halt_freeze", 32'(bus.pc_en), 32'h0);
        tick();
        bus.dbg_step = 1'b0;
        #1;
        check("st_in_step", 32'(bus.halted), 32'h0);
        check("st_lu_ctl", 32'(ctl_now()), 32'h0E);
        tick();
        idle_inputs();
        #1;
        check("st_advance", 32'(bus.pc_en), 32'h1);
        check("st_still_step", 32'(bus.halted), 32'h0);
        tick();
        check("st_halted", 32'(bus.halted), 32'h1);
        check("st_done_pulse", 32'(bus.step_done), 32'h1);
        tick();
        check("st_done_clear", 32'(bus.step_done), 32'h0);
        check("st_stall_cnt", 32'(bus.stall_cnt), 32'h3);

        // Timeout, sticky error, then reset in the middle of a step
        do_reset();
        bus.mem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("to_pre_err_c%0d", i), 32'({bus.halted, bus.mem_err}), 32'h0);
            tick();
        end
        check("to_mem_err", 32'(bus.mem_err), 32'h1);
        check("to_halted", 32'(bus.halted), 32'h1);
        check("to_stall_cnt", 32'(bus.stall_cnt), 32'h4);
        bus.mem_req = 1'b0;
        tick();
        check("to_sticky", 32'(bus.mem_err), 32'h1);
        bus.dbg_step = 1'b1;
        bus.idex_memread = 1'b1; bus.idex_rt = 5'd5; bus.ifid_rs = 5'd5;
        tick();
        bus.dbg_step = 1'b0;
        #1;
        check("rs_in_step", 32'({bus.halted, bus.pc_en}), 32'h0);
        rst = 1'b1;
        #1;
        check("rs_ctl_zero", 32'(ctl_now()), 32'h0);
        tick();
        rst = 1'b0;
        idle_inputs();
        #1;
        check("rs_run", 32'(bus.halted), 32'h0);
        check("rs_mem_err", 32'(bus.mem_err), 32'h0);
        check("rs_stall_cnt", 32'(bus.stall_cnt), 32'h0);
        check("rs_step_done", 32'(bus.step_done), 32'h0);
        check("rs_advance", 32'(bus.pc_en), 32'h1);

        // Timeout again, then resume clears the error
        bus.mem_req = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("to2_mem_err", 32'(bus.mem_err), 32'h1);
        bus.mem_req = 1'b0;
        bus.dbg_resume = 1'b1;
        tick();
        bus.dbg_resume = 1'b0;
        check("to2_resume_clear", 32'(bus.mem_err), 32'h0);
        check("to2_resume_run", 32'(bus.halted), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage MIPS core.
- Produces per-stage enable and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves load-use hazards, taken-branch flushes and data-memory wait stalls.
- Contains a debug run/halt/single-step FSM that replaces the raw breakpoint freeze.

Parameters:
- MEM_TIMEOUT, 64: consecutive data-memory wait cycles before a memory error is declared.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- idex_memread  in  1  instruction in EX is a load
- idex_rt  in  5  load destination register in EX
- ifid_rs  in  5  rs of the instruction in ID
- ifid_rt  in  5  rt of the instruction in ID
- branch_taken  in  1  branch/jump resolved taken in EX
- mem_req  in  1  MEM stage has a data-memory access in flight
- mem_ready  in  1  data memory completes the access this cycle
- bp_hit  in  1  PC matches an armed breakpoint
- dbg_halt_req  in  1  debugger halt request (level)
- dbg_step  in  1  single-step pulse
- dbg_resume  in  1  resume pulse; also clears mem_err
- pc_en  out  1  PC register update enable
- ifid_en  out  1  IF/ID register update enable
- ifid_flush  out  1  IF/ID register flush
- idex_flush  out  1  ID/EX register flush
- exmem_en  out  1  EX/MEM register update enable
- memwb_en  out  1  MEM/WB register update enable
- memwb_flush  out  1  MEM/WB register flush
- halted  out  1  FSM is in HALT
- step_done  out  1  one-cycle pulse when a single step completes
- mem_err  out  1  sticky memory-timeout flag
- stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Clocking and reset:
  - Single clock; all registers update on posedge clk.
  - Reset is synchronous and active-high.
  - While rst=1: all enables 0, all flushes 0, halted 0, step_done 0, mem_err 0, stall_cnt 0, wait_cnt 0, skip_bp 0, state RUN.
- Output timing: enable and flush outputs are combinational from the registered state and the current inputs, so there is zero latency from hazard to control. step_done, mem_err and stall_cnt are registered.
- Hazard terms:
  - memwait = mem_req & ~mem_ready
  - loaduse = idex_memread & (idex_rt != 0) & (idex_rt == ifid_rs | idex_rt == ifid_rt)
- Advance logic (ADV), applied in RUN and STEP, in priority order:
  1. memwait: pc_en=ifid_en=exmem_en=0, idex_flush=0, memwb_en=1, memwb_flush=1. Branch and load-use are ignored and re-evaluated once the stall ends.
  2. branch_taken: all enables 1, ifid_flush=1, idex_flush=1. Branch wins over loaduse if both are asserted.
  3. loaduse: pc_en=ifid_en=0, idex_flush=1, exmem_en=memwb_en=1.
  4. Otherwise: all enables 1, no flushes.
- FSM states: RUN, HALT, STEP.
- RUN:
  - halt_cond = dbg_halt_req | (bp_hit & ~skip_bp).
  - If halt_cond & ~memwait: all enables 0 this cycle (the breakpoint instruction does not advance); next state HALT.
  - If halt_cond & memwait: the halt is deferred; apply ADV until the access completes.
  - Otherwise apply ADV.
- HALT:
  - All enables 0, flushes 0, halted=1.
  - dbg_resume → RUN, set skip_bp for one RUN cycle.
  - Else dbg_step → STEP.
  - resume has priority over step.
- STEP:
  - Apply ADV; bp_hit is ignored.
  - Stay in STEP until a cycle with pc_en=1, then go to HALT.
  - step_done=1 in the first HALT cycle after the step.
- skip_bp: set on HALT→RUN, cleared after one RUN cycle. Prevents an immediate re-hit on the same PC.
- Memory timeout:
  - wait_cnt increments on memwait and clears otherwise.
  - A memwait cycle with wait_cnt == MEM_TIMEOUT-1 sets mem_err and forces HALT next cycle, overriding the deferral.
  - mem_err is sticky until dbg_resume.
- stall_cnt: increments in RUN or STEP whenever pc_en=0; saturates at 2^CNT_W-1 with no wrap.
- Simultaneous events:
  - dbg_step in RUN is ignored.
  - dbg_resume in RUN clears mem_err only.
  - rst overrides everything, including mid-step and mid-wait.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding constants (RUN=2'd0, HALT=2'd1, STEP=2'd2);
  - a stage-control bundle typedef {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_en, memwb_flush}.
- One natural sub-module, hazard_unit: purely combinational ADV logic returning the control bundle. pipe_ctrl holds the FSM, counters and halt gating.

Test Plan:
- Load-use: idex_memread=1, idex_rt=5, ifid_rs=5, no other hazards → pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1 for exactly that cycle. Repeat with idex_rt=0 → no stall.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then ready → 3 cycles of exmem_en=0 and memwb_flush=1, stall_cnt=3; a branch_taken held during the wait flushes only after the wait ends.
- Breakpoint halt and resume: bp_hit in RUN → enables 0 that cycle, halted=1 next cycle; dbg_resume with bp_hit still high → one RUN cycle of advance with no re-halt.
- Single step: in HALT pulse dbg_step with loaduse active on the first step cycle → STEP lasts 2 cycles, then HALT with a step_done 1-cycle pulse.
- Timeout: MEM_TIMEOUT=4, mem_req=1, mem_ready=0 held → mem_err=1 and halted=1 after the 4th wait cycle; dbg_resume clears mem_err.
- Reset mid-step: rst=1 during STEP → next cycle state RUN, all counters 0, mem_err 0.
